tone_scheduler: RTL and testbench

//  Shares the single song/tone generator between four sound requesters (press beep,

---
 rtl/tone_scheduler.sv | 161 ++++++++++++++++
 tb/tb_tone_scheduler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tone_scheduler.sv
// Tone scheduler: latches four request pulses, grants the highest pending clip (with
// preemption) and steps its notes from a small ROM, one beat every BEAT_DIV clk cycles.
module tone_scheduler #(
  parameter int unsigned BEAT_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       stop,
  input  logic       en,
  output logic [4:0] note,
  output logic       tone_en,
  output logic       busy,
  output logic [1:0] active_id,
  output logic       done,
  output logic [1:0] done_id
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_t;

  localparam logic [23:0] BEAT_LAST = 24'(BEAT_DIV - 1);

  state_t      state_q;
  logic [3:0]  pending_q;
  logic [1:0]  active_id_q;
  logic [2:0]  idx_q;
  logic [23:0] beat_q;
  logic [2:0]  dur_q;
  logic [4:0]  note_q;
  logic        done_q;
  logic [1:0]  done_id_q;

  // Entry = {note, dur}; dur = 0 is the end-of-clip marker.
  function automatic logic [7:0] rom_entry(input logic [1:0] id, input logic [2:0] idx);
    logic [7:0] e;
    e = 8'd0;
    case ({id, idx})
      {2'd0, 3'd0}: e = {5'd15, 3'd1};
      {2'd1, 3'd0}: e = {5'd21, 3'd1};
      {2'd2, 3'd0}: e = {5'd17, 3'd2};
      {2'd2, 3'd1}: e = {5'd0,  3'd1};
      {2'd2, 3'd2}: e = {5'd17, 3'd2};
      {2'd3, 3'd0}: e = {5'd11, 3'd1};
      {2'd3, 3'd1}: e = {5'd13, 3'd1};
      {2'd3, 3'd2}: e = {5'd15, 3'd1};
      {2'd3, 3'd3}: e = {5'd21, 3'd2};
      default:      e = 8'd0;
    endcase
    return e;
  endfunction

  function automatic logic [1:0] highest(input logic [3:0] v);
    logic [1:0] h;
    h = 2'd0;
    if (v[3])      h = 2'd3;
    else if (v[2]) h = 2'd2;
    else if (v[1]) h = 2'd1;
    return h;
  endfunction

  logic [3:0] above_d;
  logic       grant_d;
  logic [1:0] grant_id_d;
  logic [3:0] grant_mask_d;
  logic [7:0] first_d;
  logic [7:0] next_d;
  logic       tick_d;
  logic       expire_d;

  // Pending requests that outrank the clip currently granted.
  for (genvar gi = 0; gi < 4; gi++) begin : g_above
    assign above_d[gi] = pending_q[gi] && (active_id_q < 2'(gi));
  end

  always_comb begin
    grant_d    = 1'b0;
    grant_id_d = 2'd0;
    if (state_q == S_IDLE && |pending_q) begin
      grant_d    = 1'b1;
      grant_id_d = highest(pending_q);
    end else if (state_q == S_PLAY && |above_d) begin
      grant_d    = 1'b1;
      grant_id_d = highest(above_d);
    end
    grant_mask_d = grant_d ? (4'b0001 << grant_id_d) : 4'b0000;
  end

  assign first_d  = rom_entry(active_id_q, 3'd0);
  assign next_d   = rom_entry(active_id_q, idx_q + 3'd1);
  assign tick_d   = (beat_q == BEAT_LAST);
  assign expire_d = tick_d && (dur_q <= 3'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pending_q   <= 4'd0;
      active_id_q <= 2'd0;
      idx_q       <= 3'd0;
      beat_q      <= 24'd0;
      dur_q       <= 3'd0;
      note_q      <= 5'd0;
      done_q      <= 1'b0;
      done_id_q   <= 2'd0;
    end else if (stop) begin
      state_q   <= S_IDLE;
      pending_q <= 4'd0;
      note_q    <= 5'd0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      // A request in the same edge as its grant keeps the bit set.
      pending_q <= (pending_q & ~grant_mask_d) | req;
      case (state_q)
        S_IDLE: begin
          if (grant_d) begin
            state_q     <= S_LOAD;
            active_id_q <= grant_id_d;
          end
        end
        S_LOAD: begin
          state_q <= S_PLAY;
          idx_q   <= 3'd0;
          note_q  <= first_d[7:3];
          dur_q   <= first_d[2:0];
          beat_q  <= 24'd0;
        end
        S_PLAY: begin
          if (grant_d) begin
            state_q     <= S_LOAD;
            active_id_q <= grant_id_d;
          end else if (tick_d) begin
            beat_q <= 24'd0;
            if (!expire_d) begin
              dur_q <= dur_q - 3'd1;
            end else if (next_d[2:0] == 3'd0) begin
              state_q   <= S_IDLE;
              note_q    <= 5'd0;
              done_q    <= 1'b1;
              done_id_q <= active_id_q;
            end else begin
              idx_q  <= idx_q + 3'd1;
              note_q <= next_d[7:3];
              dur_q  <= next_d[2:0];
            end
          end else begin
            beat_q <= beat_q + 24'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign note      = note_q;
  assign tone_en   = (state_q == S_PLAY) && (note_q != 5'd0) && en;
  assign busy      = (state_q != S_IDLE);
  assign active_id = active_id_q;
  assign done      = done_q;
  assign done_id   = done_id_q;

endmodule

// File: tb/tb_tone_scheduler.sv
// Scoreboard bench: a per-cycle note-sequence model predicts output change events,
// and a monitor pops and compares them whenever the DUT outputs change.
module tb_tone_scheduler;
  localparam int BEAT_DIV = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       stop;
  logic       en;
  logic [4:0] note;
  logic       tone_en;
  logic       busy;
  logic [1:0] active_id;
  logic       done;
  logic [1:0] done_id;

  tone_scheduler #(.BEAT_DIV(BEAT_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .stop(stop), .en(en),
    .note(note), .tone_en(tone_en), .busy(busy), .active_id(active_id),
    .done(done), .done_id(done_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         cyc;
    logic [11:0] v;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   armed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a granted clip becomes a flat list of per-cycle notes.
  int         m_mode = 0;        // 0 idle, 1 load, 2 play
  logic [3:0] m_pend = 4'd0;
  int         m_active = 0;
  logic [4:0] m_note = 5'd0;
  bit         m_done = 0;
  int         m_done_id = 0;
  logic [4:0] m_seq[$];
  int         m_g;
  logic [11:0] last_exp = 12'd0;
  logic [11:0] exp_vec;

  function automatic int top_bit(input logic [3:0] v, input int above);
    for (int i = 3; i > above; i--) if (v[i]) return i;
    return -1;
  endfunction

  function automatic void add_note(input int nt, input int bt);
    repeat (bt * BEAT_DIV) m_seq.push_back(5'(nt));
  endfunction

  function automatic void load_clip(input int id);
    m_seq.delete();
    case (id)
      0: add_note(15, 1);
      1: add_note(21, 1);
      2: begin add_note(17, 2); add_note(0, 1); add_note(17, 2); end
      default: begin add_note(11, 1); add_note(13, 1); add_note(15, 1); add_note(21, 2); end
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_pend = 4'd0; m_active = 0; m_note = 5'd0;
      m_done = 0; m_done_id = 0; m_seq.delete();
    end else if (stop) begin
      m_mode = 0; m_pend = 4'd0; m_note = 5'd0; m_done = 0; m_seq.delete();
    end else begin
      m_done = 0;
      m_g = -1;
      case (m_mode)
        0: begin
          m_g = top_bit(m_pend, -1);
          if (m_g >= 0) begin m_mode = 1; m_active = m_g; end
        end
        1: begin
          load_clip(m_active);
          m_note = m_seq.pop_front();
          m_mode = 2;
        end
        default: begin
          m_g = top_bit(m_pend, m_active);
          if (m_g >= 0) begin
            m_mode = 1; m_active = m_g;
          end else if (m_seq.size() == 0) begin
            m_mode = 0; m_note = 5'd0; m_done = 1; m_done_id = m_active;
          end else begin
            m_note = m_seq.pop_front();
          end
        end
      endcase
      if (m_g >= 0) m_pend[m_g] = 1'b0;
      m_pend = m_pend | req;
    end
    #2;
    exp_vec = {m_note, (m_mode == 2 && m_note != 5'd0 && en), (m_mode != 0),
               2'(m_active), m_done, 2'(m_done_id)};
    if (armed && exp_vec !== last_exp) exp_q.push_back('{cyc, exp_vec});
    last_exp = exp_vec;
  end

  // Monitor: every DUT output change must match the next predicted event and its cycle.
  logic [11:0] mon_last = 12'd0;
  logic [11:0] dut_vec;
  ev_t         ev;

  always @(negedge clk) begin
    if (armed) begin
      dut_vec = {note, tone_en, busy, active_id, done, done_id};
      if (dut_vec !== mon_last) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event cyc=%0d got=%h required=no_change", cyc, dut_vec);
        end else begin
          ev = exp_q.pop_front();
          if (ev.cyc != cyc || ev.v !== dut_vec) begin
            failures++;
            $display("FAIL event got=%h@cyc%0d required=%h@cyc%0d", dut_vec, cyc, ev.v, ev.cyc);
          end
        end
        mon_last = dut_vec;
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_event got=%h@cyc%0d required=%h@cyc%0d",
                 dut_vec, cyc, exp_q[0].v, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, want);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic s, input logic e, input int n);
    req = r; stop = s; en = e;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] r;
    logic       s;
    logic       e;

    rst_n = 1'b0; req = 4'hF; stop = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    armed = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outputs", {note, tone_en, busy, active_id, done, done_id}, 12'd0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    drive(4'b0000, 0, 1, 6);

    drive(4'b0001, 0, 1, 1);  drive(4'b0000, 0, 1, 20);   // clip 0
    drive(4'b0100, 0, 1, 1);  drive(4'b0000, 0, 1, 30);   // clip 2 with rest
    drive(4'b1000, 0, 1, 1);  drive(4'b0000, 0, 1, 6);
    drive(4'b0001, 0, 1, 1);  drive(4'b0000, 0, 1, 40);   // lower waits for clip 3
    drive(4'b0100, 0, 1, 1);  drive(4'b0000, 0, 1, 12);
    drive(4'b1000, 0, 1, 1);  drive(4'b0000, 0, 1, 40);   // preempt clip 2
    drive(4'b0110, 0, 1, 1);  drive(4'b0000, 0, 1, 8);
    drive(4'b0000, 1, 1, 1);  drive(4'b0000, 0, 1, 20);   // stop clears pending
    drive(4'b1000, 0, 0, 1);  drive(4'b0000, 0, 0, 30);   // gated run
    drive(4'b1000, 1, 1, 1);  drive(4'b0000, 0, 1, 10);   // stop beats req
    drive(4'b0010, 0, 1, 1);  drive(4'b0010, 0, 1, 4);    // re-request of active clip
    drive(4'b0000, 0, 1, 30);

    e = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15) & $urandom_range(0, 15)) : 4'd0;
      s = ($urandom_range(0, 120) == 0);
      if ($urandom_range(0, 40) == 0) e = ~e;
      rst_n = ($urandom_range(0, 700) != 0);
      drive(r, s, e, 1);
    end
    rst_n = 1'b1;
    drive(4'b0000, 0, 1, 60);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d_pending_events required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
